// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter sharing the register-file write port; define ARB_LOCK_EN to add the lock input for back-to-back grants
module regfile_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]    lock,
`endif
  output logic [NREQ-1:0]    gnt,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic [2**AW-1:0]   wr_sel,
  output logic               busy
);
  localparam int PW = $clog2(NREQ);
  logic [NREQ-1:0] gnt_q, gnt_d, elig;
  logic            wr_en_q, wr_en_d, found;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d, idx, win;
`ifdef ARB_LOCK_EN
  logic [PW-1:0]   held;
  logic            hold;
`endif
  // pick the first eligible requester from rr_ptr; a locked holder overrides the scan and keeps the pointer
  always_comb begin
    elig  = req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr_q + PW'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    rr_ptr_d = found ? win + 1'b1 : rr_ptr_q;
`ifdef ARB_LOCK_EN
    held = '0;
    for (int k = 0; k < NREQ; k++)
      if (gnt_q[k]) held = PW'(k);
    hold = |(gnt_q & lock & req);
    if (hold) begin
      found    = 1'b1;
      win      = held;
      rr_ptr_d = rr_ptr_q;
    end
`endif
    gnt_d     = found ? NREQ'(1) << win : '0;
    wr_en_d   = found;
    wr_addr_d = found ? req_addr[win*AW +: AW] : wr_addr_q;
    wr_data_d = found ? req_data[win*DW +: DW] : wr_data_q;
  end
  // grant and write-port registers; reset drops any write in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end
  assign gnt     = gnt_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_sel  = (wr_en_q && |wr_addr_q) ? {{(2**AW-1){1'b0}}, 1'b1} << wr_addr_q : '0;
  assign busy    = |req | wr_en_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: randomized and directed checks of regfile_wr_arbiter against a behavioural model
module tb_regfile_wr_arbiter;
  localparam int N = 4, AW = 5, DW = 32;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0] lock = '0;
  logic [N-1:0] gnt;
  logic wr_en, busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [2**AW-1:0] wr_sel;
  int n_cmp = 0, n_err = 0;
  int m_ptr = 0, m_gnt = -1;
  logic m_en = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  regfile_wr_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_sel(wr_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] e_gnt();
    return m_gnt < 0 ? '0 : N'(1) << m_gnt;
  endfunction
  function automatic logic [2**AW-1:0] e_sel();
    return (m_en && m_addr != 0) ? (2**AW)'(1) << m_addr : '0;
  endfunction

  // apply the arbitration rules to the current inputs, then advance one clock
  task automatic step();
    int w = -1;
`ifdef ARB_LOCK_EN
    if (m_gnt >= 0 && lock[m_gnt] && req[m_gnt]) w = m_gnt;
`endif
    if (w < 0)
      for (int k = 0; k < N; k++) begin
        int i = (m_ptr + k) % N;
        if (w < 0 && req[i] && m_gnt != i) w = i;
      end
`ifdef ARB_LOCK_EN
    if (w >= 0 && !(w == m_gnt)) m_ptr = (w + 1) % N;
`else
    if (w >= 0) m_ptr = (w + 1) % N;
`endif
    if (w >= 0) begin
      m_addr = req_addr[w*AW +: AW];
      m_data = req_data[w*DW +: DW];
    end
    m_gnt = w;
    m_en = w >= 0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({gnt, wr_en, wr_addr, wr_data, wr_sel} !== '0) begin
      n_err++; $display("FAIL reset_state: got gnt=%b wr_en=%b addr=%0d data=%h sel=%h want all 0", gnt, wr_en, wr_addr, wr_data, wr_sel);
    end
    @(posedge clk); #1 rst_n = 1;
    set_req(1, 5'd7, 32'hCAFE0001);
    step();
    req = '0;
    n_cmp++;
    if (wr_en !== 1'b1 || gnt !== 4'b0010) begin
      n_err++; $display("FAIL pre_reset_write: got wr_en=%b gnt=%b want 1 0010", wr_en, gnt);
    end
    #3 rst_n = 0;
    #1;
    n_cmp++;
    if ({gnt, wr_en, wr_addr, wr_data, wr_sel} !== '0) begin
      n_err++; $display("FAIL reset_mid_write: got gnt=%b wr_en=%b addr=%0d data=%h sel=%h want all 0", gnt, wr_en, wr_addr, wr_data, wr_sel);
    end
    m_ptr = 0; m_gnt = -1; m_en = 0; m_addr = '0; m_data = '0;
    @(posedge clk); #1 rst_n = 1;
    step();
    n_cmp++;
    if (wr_en !== 1'b0 || gnt !== '0) begin
      n_err++; $display("FAIL reset_idle: got wr_en=%b gnt=%b want 0 0000", wr_en, gnt);
    end
  endtask

  task automatic test_all_rr();
    logic [N-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), $urandom);
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if (gnt !== seq[c] || gnt !== e_gnt() || wr_en !== 1'b1 || wr_data !== m_data || wr_addr !== m_addr) begin
        n_err++; $display("FAIL all_rr[%0d]: got gnt=%b en=%b addr=%0d data=%h want gnt=%b en=1 addr=%0d data=%h", c, gnt, wr_en, wr_addr, wr_data, seq[c], m_addr, m_data);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_single();
    set_req(2, 5'd9, 32'hDEADBEEF);
    step();
    n_cmp++;
    if (gnt !== 4'b0100 || wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'hDEADBEEF || wr_sel !== 32'h200) begin
      n_err++; $display("FAIL single_grant: got gnt=%b en=%b addr=%0d data=%h sel=%h want 0100 1 9 deadbeef 00000200", gnt, wr_en, wr_addr, wr_data, wr_sel);
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || wr_en !== 1'b0 || wr_sel !== '0 || busy !== 1'b1) begin
      n_err++; $display("FAIL single_gap: got gnt=%b en=%b sel=%h busy=%b want 0000 0 0 1", gnt, wr_en, wr_sel, busy);
    end
    req = '0;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL idle_busy: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_addr_zero();
    set_req(1, 5'd0, 32'h1234);
    step();
    req = '0;
    n_cmp++;
    if (gnt !== 4'b0010 || wr_en !== 1'b1 || wr_sel !== '0 || wr_data !== 32'h1234) begin
      n_err++; $display("FAIL addr_zero: got gnt=%b en=%b sel=%h data=%h want 0010 1 0 00001234", gnt, wr_en, wr_sel, wr_data);
    end
    step();
  endtask

  task automatic test_wrap();
    set_req(2, 5'd3, 32'h22);
    step();
    req = '0;
    set_req(3, 5'd12, 32'h33);
    set_req(0, 5'd31, 32'h00);
    step();
    n_cmp++;
    if (gnt !== 4'b1000 || wr_addr !== 5'd12 || wr_data !== 32'h33) begin
      n_err++; $display("FAIL wrap_first: got gnt=%b addr=%0d data=%h want 1000 12 33", gnt, wr_addr, wr_data);
    end
    req[3] = 1'b0;
    step();
    n_cmp++;
    if (gnt !== 4'b0001 || wr_addr !== 5'd31 || wr_sel !== 32'h80000000) begin
      n_err++; $display("FAIL wrap_second: got gnt=%b addr=%0d sel=%h want 0001 31 80000000", gnt, wr_addr, wr_sel);
    end
    req = '0;
    step();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] seq [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
    set_req(1, 5'd1, 32'h1);
    step();
    req = '0;
    step();
    lock = 4'b0100;
    set_req(2, 5'd4, 32'h44);
    set_req(0, 5'd5, 32'h55);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) req[2] = 1'b0;
      step();
      n_cmp++;
      if (gnt !== seq[c] || gnt !== e_gnt()) begin
        n_err++; $display("FAIL lock[%0d]: got gnt=%b want %b", c, gnt, seq[c]);
      end
    end
    req = '0;
    lock = '0;
    step();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW] = AW'($urandom);
        req_data[i*DW +: DW] = $urandom;
      end
      step();
      n_cmp++;
      if (gnt !== e_gnt() || wr_en !== m_en || wr_addr !== m_addr || wr_data !== m_data || wr_sel !== e_sel() || busy !== (|req || m_en)) begin
        n_err++; $display("FAIL random[%0d]: got gnt=%b en=%b addr=%0d data=%h sel=%h busy=%b want gnt=%b en=%b addr=%0d data=%h sel=%h", c, gnt, wr_en, wr_addr, wr_data, wr_sel, busy, e_gnt(), m_en, m_addr, m_data, e_sel());
      end
    end
    req = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_all_rr();
    test_single();
    test_addr_zero();
    test_wrap();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
